// File: rtl/unit_mover.sv
// Per-frame movement stage: owns 16 friendly and 16 enemy unit slots, steps
// every live unit toward the opposing front once per start pulse, and handles spawns/kills.
module unit_mover (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         ack,
  input  logic [8:0]   friendlyFront,
  input  logic [8:0]   enemyFront,
  input  logic         spawnF,
  input  logic [1:0]   spawnFType,
  input  logic         spawnE,
  input  logic [1:0]   spawnEType,
  input  logic [15:0]  killF,
  input  logic [15:0]  killE,
  output logic [143:0] unitLocFlat,
  output logic [31:0]  unitTypeFlat,
  output logic [143:0] enemyLocFlat,
  output logic [31:0]  enemyTypeFlat,
  output logic [15:0]  unitAttack,
  output logic [15:0]  enemyAttack,
  output logic         spawnReady,
  output logic         spawnDropF,
  output logic         spawnDropE,
  output logic         done
);
  localparam logic [8:0] FSPAWN = 9'd480;
  localparam logic [8:0] ESPAWN = 9'd32;

  // Handshake: start is a one-cycle pulse accepted only in S_IDLE; done is held
  // in S_DONE until ack is sampled high; spawns are honoured only while spawnReady.
  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [1:0]  ftype_q [16];
  logic [1:0]  ftype_d [16];
  logic [8:0]  floc_q  [16];
  logic [8:0]  floc_d  [16];
  logic [1:0]  etype_q [16];
  logic [1:0]  etype_d [16];
  logic [8:0]  eloc_q  [16];
  logic [8:0]  eloc_d  [16];
  logic [15:0] fatk_q, fatk_d, eatk_q, eatk_d;
  logic        dropf_q, dropf_d, drope_q, drope_d;

  function automatic logic [9:0] speed(input logic [1:0] t);
    case (t)
      2'd1:    speed = 10'd2;
      2'd2:    speed = 10'd1;
      2'd3:    speed = 10'd4;
      default: speed = 10'd0;
    endcase
  endfunction

  // Movement arithmetic for the slot currently addressed by idx_q (10-bit, no wrap)
  logic [9:0] f_cur, f_spd, f_fr, f_dec, e_cur, e_spd, e_fr, e_sum;
  logic [8:0] f_step, e_step;
  assign f_cur  = {1'b0, floc_q[idx_q]};
  assign f_spd  = speed(ftype_q[idx_q]);
  assign f_fr   = {1'b0, enemyFront};
  assign f_dec  = f_cur - f_spd;
  assign f_step = (f_cur <= f_fr + f_spd) ? enemyFront : f_dec[8:0];
  assign e_cur  = {1'b0, eloc_q[idx_q]};
  assign e_spd  = speed(etype_q[idx_q]);
  assign e_fr   = {1'b0, friendlyFront};
  assign e_sum  = e_cur + e_spd;
  assign e_step = (e_sum >= e_fr) ? friendlyFront : e_sum[8:0];

  // Lowest-index empty slot, taken from the pre-edge types
  logic       f_free, e_free;
  logic [3:0] f_slot, e_slot;
  always_comb begin
    f_free = 1'b0;
    f_slot = 4'd0;
    e_free = 1'b0;
    e_slot = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (ftype_q[i] == 2'd0) begin
        f_free = 1'b1;
        f_slot = 4'(i);
      end
      if (etype_q[i] == 2'd0) begin
        e_free = 1'b1;
        e_slot = 4'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ftype_d = ftype_q;
    floc_d  = floc_q;
    etype_d = etype_q;
    eloc_d  = eloc_q;
    fatk_d  = fatk_q;
    eatk_d  = eatk_q;
    dropf_d = 1'b0;
    drope_d = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_MOVE;
        idx_d   = 4'd0;
      end
      S_MOVE: begin
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) state_d = S_DONE;
        if (ftype_q[idx_q] == 2'd0) begin
          fatk_d[idx_q] = 1'b0;
        end else if (f_cur > f_fr) begin
          floc_d[idx_q] = f_step;
          fatk_d[idx_q] = 1'b0;
        end else begin
          fatk_d[idx_q] = 1'b1;
        end
        if (etype_q[idx_q] == 2'd0) begin
          eatk_d[idx_q] = 1'b0;
        end else if (e_cur < e_fr) begin
          eloc_d[idx_q] = e_step;
          eatk_d[idx_q] = 1'b0;
        end else begin
          eatk_d[idx_q] = 1'b1;
        end
      end
      S_DONE: if (ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_MOVE) begin
      if (spawnF && spawnFType != 2'd0) begin
        if (f_free) begin
          ftype_d[f_slot] = spawnFType;
          floc_d[f_slot]  = FSPAWN;
          fatk_d[f_slot]  = 1'b0;
        end else begin
          dropf_d = 1'b1;
        end
      end
      if (spawnE && spawnEType != 2'd0) begin
        if (e_free) begin
          etype_d[e_slot] = spawnEType;
          eloc_d[e_slot]  = ESPAWN;
          eatk_d[e_slot]  = 1'b0;
        end else begin
          drope_d = 1'b1;
        end
      end
    end
    // Kill wins over both movement and spawn of the same slot; loc is left stale
    for (int i = 0; i < 16; i++) begin
      if (killF[i]) begin
        ftype_d[i] = 2'd0;
        fatk_d[i]  = 1'b0;
      end
      if (killE[i]) begin
        etype_d[i] = 2'd0;
        eatk_d[i]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      for (int i = 0; i < 16; i++) begin
        ftype_q[i] <= 2'd0;
        floc_q[i]  <= 9'd0;
        etype_q[i] <= 2'd0;
        eloc_q[i]  <= 9'd0;
      end
      fatk_q  <= 16'd0;
      eatk_q  <= 16'd0;
      dropf_q <= 1'b0;
      drope_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ftype_q <= ftype_d;
      floc_q  <= floc_d;
      etype_q <= etype_d;
      eloc_q  <= eloc_d;
      fatk_q  <= fatk_d;
      eatk_q  <= eatk_d;
      dropf_q <= dropf_d;
      drope_q <= drope_d;
    end
  end

  always_comb begin
    unitLocFlat   = '0;
    unitTypeFlat  = '0;
    enemyLocFlat  = '0;
    enemyTypeFlat = '0;
    for (int i = 0; i < 16; i++) begin
      unitLocFlat[9*i +: 9]   = floc_q[i];
      unitTypeFlat[2*i +: 2]  = ftype_q[i];
      enemyLocFlat[9*i +: 9]  = eloc_q[i];
      enemyTypeFlat[2*i +: 2] = etype_q[i];
    end
  end

  assign unitAttack  = fatk_q;
  assign enemyAttack = eatk_q;
  assign spawnReady  = (state_q != S_MOVE);
  assign spawnDropF  = dropf_q;
  assign spawnDropE  = drope_q;
  assign done        = (state_q == S_DONE);
endmodule

// File: tb/tb_unit_mover.sv
// Bench for unit_mover: behavioural slot model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_unit_mover;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, ack, spawnF, spawnE;
  logic [8:0]   friendlyFront, enemyFront;
  logic [1:0]   spawnFType, spawnEType;
  logic [15:0]  killF, killE;
  logic [143:0] unitLocFlat, enemyLocFlat;
  logic [31:0]  unitTypeFlat, enemyTypeFlat;
  logic [15:0]  unitAttack, enemyAttack;
  logic         spawnReady, spawnDropF, spawnDropE, done;

  int checks = 0;
  int errors = 0;

  unit_mover dut (
    .clk(clk), .rst(rst), .start(start), .ack(ack),
    .friendlyFront(friendlyFront), .enemyFront(enemyFront),
    .spawnF(spawnF), .spawnFType(spawnFType), .spawnE(spawnE), .spawnEType(spawnEType),
    .killF(killF), .killE(killE),
    .unitLocFlat(unitLocFlat), .unitTypeFlat(unitTypeFlat),
    .enemyLocFlat(enemyLocFlat), .enemyTypeFlat(enemyTypeFlat),
    .unitAttack(unitAttack), .enemyAttack(enemyAttack),
    .spawnReady(spawnReady), .spawnDropF(spawnDropF), .spawnDropE(spawnDropE), .done(done)
  );

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_ft[16], m_fl[16], m_fa[16], m_et[16], m_el[16], m_ea[16];
  int m_phase = 0;  // 0 idle, 1 pass in progress, 2 waiting for ack
  int m_k = 0;      // slot handled in the current pass cycle
  bit m_dropf = 0, m_drope = 0, m_valid = 0;

  function automatic int spd(input int t);
    return (t == 1) ? 2 : (t == 2) ? 1 : (t == 3) ? 4 : 0;
  endfunction

  always @(posedge clk) begin : model
    int nft[16], nfl[16], nfa[16], net[16], nel[16], nea[16];
    int t, ef, ff, fs, es;
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_ft[i] = 0; m_fl[i] = 0; m_fa[i] = 0; m_et[i] = 0; m_el[i] = 0; m_ea[i] = 0;
      end
      m_phase = 0; m_k = 0; m_dropf = 0; m_drope = 0; m_valid = 1;
    end else begin
      nft = m_ft; nfl = m_fl; nfa = m_fa; net = m_et; nel = m_el; nea = m_ea;
      ef = int'(enemyFront);
      ff = int'(friendlyFront);
      m_dropf = 0; m_drope = 0;
      if (m_phase == 1) begin
        if (m_ft[m_k] == 0) nfa[m_k] = 0;
        else if (m_fl[m_k] > ef) begin
          t = m_fl[m_k] - spd(m_ft[m_k]);
          nfl[m_k] = (t < ef) ? ef : t;
          nfa[m_k] = 0;
        end else nfa[m_k] = 1;
        if (m_et[m_k] == 0) nea[m_k] = 0;
        else if (m_el[m_k] < ff) begin
          t = m_el[m_k] + spd(m_et[m_k]);
          nel[m_k] = (t > ff) ? ff : t;
          nea[m_k] = 0;
        end else nea[m_k] = 1;
      end else begin
        fs = -1; es = -1;
        for (int i = 15; i >= 0; i--) begin
          if (m_ft[i] == 0) fs = i;
          if (m_et[i] == 0) es = i;
        end
        if (spawnF && spawnFType != 0) begin
          if (fs >= 0) begin nft[fs] = int'(spawnFType); nfl[fs] = 480; nfa[fs] = 0; end
          else m_dropf = 1;
        end
        if (spawnE && spawnEType != 0) begin
          if (es >= 0) begin net[es] = int'(spawnEType); nel[es] = 32; nea[es] = 0; end
          else m_drope = 1;
        end
      end
      for (int i = 0; i < 16; i++) begin
        if (killF[i]) begin nft[i] = 0; nfa[i] = 0; end
        if (killE[i]) begin net[i] = 0; nea[i] = 0; end
      end
      if (m_phase == 0 && start) begin m_phase = 1; m_k = 0; end
      else if (m_phase == 1) begin
        if (m_k == 15) m_phase = 2;
        m_k = (m_k + 1) % 16;
      end else if (m_phase == 2 && ack) m_phase = 0;
      m_ft = nft; m_fl = nfl; m_fa = nfa; m_et = net; m_el = nel; m_ea = nea;
    end
  end

  always @(negedge clk) begin : compare
    logic [143:0] ul, el;
    logic [31:0] ut, et;
    logic [15:0] ua, ea;
    if (m_valid) begin
      for (int i = 0; i < 16; i++) begin
        ul[9*i +: 9] = 9'(m_fl[i]); el[9*i +: 9] = 9'(m_el[i]);
        ut[2*i +: 2] = 2'(m_ft[i]); et[2*i +: 2] = 2'(m_et[i]);
        ua[i] = m_fa[i][0]; ea[i] = m_ea[i][0];
      end
      check("unitLocFlat", unitLocFlat, ul);
      check("unitTypeFlat", unitTypeFlat, ut);
      check("enemyLocFlat", enemyLocFlat, el);
      check("enemyTypeFlat", enemyTypeFlat, et);
      check("unitAttack", unitAttack, ua);
      check("enemyAttack", enemyAttack, ea);
      check("spawnReady", spawnReady, m_phase != 1);
      check("spawnDropF", spawnDropF, m_dropf);
      check("spawnDropE", spawnDropE, m_drope);
      check("done", done, m_phase == 2);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [8:0] floc(input int i); return unitLocFlat[9*i +: 9]; endfunction
  function automatic logic [8:0] eloc(input int i); return enemyLocFlat[9*i +: 9]; endfunction
  function automatic logic [1:0] ftyp(input int i); return unitTypeFlat[2*i +: 2]; endfunction
  function automatic logic [1:0] etyp(input int i); return enemyTypeFlat[2*i +: 2]; endfunction

  task automatic do_spawnF(input logic [1:0] t);
    spawnF = 1'b1; spawnFType = t;
    @(negedge clk);
    spawnF = 1'b0; spawnFType = 2'd0;
  endtask

  task automatic do_spawnE(input logic [1:0] t);
    spawnE = 1'b1; spawnEType = t;
    @(negedge clk);
    spawnE = 1'b0; spawnEType = 2'd0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    forever begin
      @(posedge clk);
      lat++;
      #1 start = 1'b0;
      if (done) break;
      if (lat >= 40) begin
        errors++;
        $display("FAIL done_timeout: got no done after %0d edges required within 40", lat);
        break;
      end
    end
    checks++;
  endtask

  task automatic ack_done();
    @(negedge clk) ack = 1'b1;
    @(negedge clk) ack = 1'b0;
  endtask

  task automatic run_pass(input logic [8:0] ef, input logic [8:0] ff, output int lat);
    enemyFront = ef; friendlyFront = ff; start = 1'b1;
    wait_done(lat);
    ack_done();
  endtask

  initial begin
    int lat;
    logic [31:0] exp_et;
    rst = 1'b1; start = 0; ack = 0; spawnF = 0; spawnE = 0; spawnFType = 0; spawnEType = 0;
    killF = 0; killE = 0; friendlyFront = 0; enemyFront = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_types", {unitTypeFlat, enemyTypeFlat}, 64'd0);
    check("reset_done", done, 1'b0);
    check("reset_ready", spawnReady, 1'b1);

    do_spawnF(2'd1);
    check("spawn0_type", ftyp(0), 2'd1);
    check("spawn0_loc", floc(0), 9'd480);
    do_spawnF(2'd3);
    check("spawn1_type", ftyp(1), 2'd3);
    check("spawn1_loc", floc(1), 9'd480);
    killF = 16'h0002;
    @(negedge clk) killF = 16'h0;
    check("kill1_type", ftyp(1), 2'd0);

    run_pass(9'd7, 9'd0, lat);
    check("latency", lat, 17);
    check("move_478", floc(0), 9'd478);
    check("move_atk0", unitAttack[0], 1'b0);

    do_spawnF(2'd3);
    run_pass(9'd477, 9'd0, lat);
    check("clamp_477", floc(1), 9'd477);
    repeat (117) run_pass(9'd7, 9'd0, lat);
    check("reach_9", floc(1), 9'd9);
    run_pass(9'd7, 9'd0, lat);
    check("clamp_7", floc(1), 9'd7);
    check("clamp_7_atk", unitAttack[1], 1'b0);
    run_pass(9'd7, 9'd0, lat);
    check("halt_7", floc(1), 9'd7);
    check("halt_7_atk", unitAttack[1], 1'b1);

    repeat (4) do_spawnE(2'd2);
    do_spawnE(2'd3);
    check("espawn4_loc", eloc(4), 9'd32);
    repeat (117) run_pass(9'd7, 9'd511, lat);
    check("enemy_500", eloc(4), 9'd500);
    run_pass(9'd7, 9'd502, lat);
    check("enemy_clamp_502", eloc(4), 9'd502);
    check("enemy_clamp_atk", enemyAttack[4], 1'b0);
    repeat (2) run_pass(9'd7, 9'd511, lat);
    check("enemy_510", eloc(4), 9'd510);
    run_pass(9'd7, 9'd505, lat);
    check("enemy_stay_510", eloc(4), 9'd510);
    check("enemy_stay_atk", enemyAttack[4], 1'b1);

    // fill the enemy array, then overflow it
    repeat (11) do_spawnE(2'd1);
    for (int i = 0; i < 16; i++) exp_et[2*i +: 2] = (i < 4) ? 2'd2 : (i == 4) ? 2'd3 : 2'd1;
    check("full_types", enemyTypeFlat, exp_et);
    do_spawnE(2'd2);
    check("drop_pulse", spawnDropE, 1'b1);
    check("drop_no_change", enemyTypeFlat, exp_et);
    @(negedge clk);
    check("drop_one_cycle", spawnDropE, 1'b0);

    // spawns during a pass are silently ignored
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    spawnE = 1'b1; spawnEType = 2'd2; spawnF = 1'b1; spawnFType = 2'd3;
    repeat (3) begin
      @(negedge clk);
      check("move_no_drop", spawnDropE, 1'b0);
    end
    spawnE = 1'b0; spawnEType = 2'd0; spawnF = 1'b0; spawnFType = 2'd0;
    wait_done(lat);
    ack_done();
    check("move_no_spawn", ftyp(2), 2'd0);

    // kill of slot 3 while the pass is handling slot 3
    repeat (3) do_spawnF(2'd3);
    run_pass(9'd480, 9'd505, lat);
    check("slot3_atk_before", unitAttack[3], 1'b1);
    start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 killF = 16'h0008;
    @(posedge clk) #1 killF = 16'h0;
    wait_done(lat);
    ack_done();
    check("kill3_type", ftyp(3), 2'd0);
    check("kill3_atk", unitAttack[3], 1'b0);

    // same-cycle kill and spawn: the killed slot is not yet free
    killF = 16'h0001; spawnF = 1'b1; spawnFType = 2'd2;
    @(negedge clk);
    killF = 16'h0; spawnF = 1'b0; spawnFType = 2'd0;
    check("ks_slot3_type", ftyp(3), 2'd2);
    check("ks_slot0_type", ftyp(0), 2'd0);
    killF = 16'h0002; spawnF = 1'b1; spawnFType = 2'd1;
    @(negedge clk);
    killF = 16'h0; spawnF = 1'b0; spawnFType = 2'd0;
    check("ks_slot0_new", ftyp(0), 2'd1);
    check("ks_slot1_killed", ftyp(1), 2'd0);

    // reset in the middle of a pass (slot 8)
    start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk) #1 rst = 1'b0;
    @(negedge clk);
    check("rst_loc", {unitLocFlat, enemyLocFlat}, 288'd0);
    check("rst_type", {unitTypeFlat, enemyTypeFlat}, 64'd0);
    check("rst_atk", {unitAttack, enemyAttack}, 32'd0);
    check("rst_done", done, 1'b0);
    check("rst_ready", spawnReady, 1'b1);
    repeat (20) @(negedge clk);
    check("rst_idle", done, 1'b0);

    // done holds without ack; start during DONE is ignored
    start = 1'b1;
    wait_done(lat);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      start = (i == 10);
      check("done_hold", done, 1'b1);
    end
    start = 1'b0;
    ack_done();
    check("done_released", done, 1'b0);
    repeat (20) @(negedge clk);
    check("start_in_done_ignored", {done, spawnReady}, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
